// File: rtl/interval_arbiter_pkg.sv
// ============================================================
// Module : interval_arbiter_pkg
// Brief  : shared states, defaults and round-robin pick helper
// Rev    : 1.0
// ============================================================
`default_nettype none

package interval_arbiter_pkg;

  localparam int N_DEF  = 8;
  localparam int R_DEF  = 4;
  localparam int RR_MAX = 32;
  localparam int IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scan last+1 .. r-1, 0 .. last; first set bit wins.
  function automatic pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                    input logic [IDX_W-1:0]  last,
                                    input int                r);
    pick_t p;
    int    c;
    p = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      c = int'(last) + k;
      if (c >= r) c = c - r;
      if (k <= r && !p.valid && req[c[IDX_W-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = c[IDX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/interval_arbiter_if.sv
// ============================================================
// Module : interval_arbiter_if
// Brief  : requester-side bus of the interval arbiter
// Rev    : 1.0
// ============================================================
`default_nettype none

interface interval_arbiter_if
  import interval_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) ();

  logic [R-1:0]   req;
  logic [R*N-1:0] dur;
  logic           abort;
  logic [R-1:0]   gnt;
  logic [R-1:0]   done;
  logic           busy;
  logic [N-1:0]   count;

  modport master (output req, dur, abort, input gnt, done, busy, count);
  modport slave  (input req, dur, abort, output gnt, done, busy, count);

endinterface

`default_nettype wire

// File: rtl/interval_counter.sv
// ============================================================
// Module : interval_counter
// Brief  : N-bit loadable down-counter that saturates at zero
// Rev    : 1.0
// ============================================================
`default_nettype none

module interval_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [N-1:0] count,
  output logic         le1
);

  logic [N-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr)
      r_count <= '0;
    else if (load)
      r_count <= din;
    else if (en && r_count != '0)
      r_count <= r_count - N'(1);
  end

  assign count = r_count;
  assign le1   = (r_count <= N'(1));

endmodule

`default_nettype wire

// File: rtl/interval_arbiter.sv
// ============================================================
// Module : interval_arbiter
// Brief  : round-robin sharing of one interval down-counter
// Rev    : 1.0
// ============================================================
`default_nettype none

module interval_arbiter
  import interval_arbiter_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic               clk,
  input  logic               clr,
  interval_arbiter_if.slave  bus
);

  state_t           r_state;
  logic [IDX_W-1:0] r_cur;
  logic [IDX_W-1:0] r_last;
  logic [R-1:0]     r_gnt;
  logic [R-1:0]     r_done;
  logic             r_busy;

  pick_t            w_pick;
  logic [N-1:0]     w_dur;
  logic [N-1:0]     w_din;
  logic             w_load;
  logic             w_en;
  logic             w_le1;
  logic [N-1:0]     w_count;

  always_comb begin
    w_pick = rr_pick(RR_MAX'(bus.req), r_last, R);
    w_dur  = bus.dur[w_pick.idx*N +: N];
  end

  // A zero duration still occupies the counter for one cycle.
  always_comb begin
    w_load = 1'b0;
    w_en   = 1'b0;
    w_din  = '0;
    case (r_state)
      IDLE: begin
        w_load = w_pick.valid;
        w_din  = (w_dur == '0) ? N'(1) : w_dur;
      end
      RUN: begin
        w_load = bus.abort || w_le1;
        w_en   = !bus.abort && !w_le1;
      end
      default: ;
    endcase
  end

  interval_counter #(.N(N)) u_counter (
    .clk   (clk),
    .clr   (clr),
    .load  (w_load),
    .en    (w_en),
    .din   (w_din),
    .count (w_count),
    .le1   (w_le1)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_last  <= IDX_W'(R - 1);
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (w_pick.valid) begin
            r_cur   <= w_pick.idx;
            r_last  <= w_pick.idx;
            r_gnt   <= R'(1) << w_pick.idx;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_le1) begin
            r_gnt   <= '0;
            r_done  <= R'(1) << r_cur;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.done  = r_done;
  assign bus.busy  = r_busy;
  assign bus.count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_interval_arbiter.sv
// ============================================================
// Module : tb_interval_arbiter
// Brief  : scoreboard bench, one expected record per clock cycle
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_interval_arbiter;

  localparam int N = 8;
  localparam int R = 4;

  typedef struct {
    logic [R-1:0] gnt;
    logic [R-1:0] done;
    logic         busy;
    logic [N-1:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  interval_arbiter_if #(.N(N), .R(R)) bus ();

  interval_arbiter #(.N(N), .R(R)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic push(input logic [R-1:0] g, input logic [R-1:0] d,
                      input logic b, input logic [N-1:0] c);
    exp_t e;
    e.gnt = g; e.done = d; e.busy = b; e.count = c;
    sb.push_back(e);
  endtask

  task automatic push_idle();
    push('0, '0, 1'b0, '0);
  endtask

  // Full grant: max(d,1) RUN cycles, one DONE cycle, one IDLE cycle.
  task automatic push_grant(input int i, input int d);
    int n;
    n = (d == 0) ? 1 : d;
    for (int k = 0; k < n; k++)
      push(R'(1) << i, '0, 1'b1, N'(n - k));
    push('0, R'(1) << i, 1'b1, '0);
    push_idle();
  endtask

  task automatic step_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("gnt",   32'(bus.gnt),   32'(e.gnt));
      chk("done",  32'(bus.done),  32'(e.done));
      chk("busy",  32'(bus.busy),  32'(e.busy));
      chk("count", 32'(bus.count), 32'(e.count));
    end
  endtask

  task automatic drain();
    while (sb.size() != 0) step_check();
  endtask

  task automatic set_dur(input int i, input int v);
    bus.dur[i*N +: N] = N'(v);
  endtask

  initial begin
    bus.req   = '1;
    bus.abort = 1'b0;
    bus.dur   = '0;
    for (int i = 0; i < R; i++) set_dur(i, 3);

    // Reset held with every request up; outputs stay at zero.
    push_idle(); push_idle();
    drain();
    clr = 1'b0;
    push_grant(0, 3);
    step_check();
    bus.req = '0;
    drain();

    // Single request, duration 5.
    set_dur(2, 5);
    bus.req = 4'b0100;
    push_grant(2, 5);
    step_check();
    bus.req = '0;
    drain();

    // Round-robin from a fresh reset with all requests held.
    clr = 1'b1;
    push_idle();
    step_check();
    clr = 1'b0;
    for (int i = 0; i < R; i++) set_dur(i, 2);
    bus.req = 4'b1111;
    push_grant(0, 2); push_grant(1, 2); push_grant(2, 2);
    push_grant(3, 2); push_grant(0, 2);
    drain();
    bus.req = '0;

    // Zero duration behaves like one cycle.
    set_dur(1, 0);
    bus.req = 4'b0010;
    push_grant(1, 0);
    step_check();
    bus.req = '0;
    drain();

    // Abort at count 3; no done, next grant goes to requester 1.
    set_dur(0, 6);
    set_dur(1, 2);
    bus.req = 4'b0011;
    for (int k = 6; k >= 3; k--) push(4'b0001, '0, 1'b1, N'(k));
    step_check();
    bus.req = 4'b0010;
    repeat (3) step_check();
    bus.abort = 1'b1;
    push_idle();
    step_check();
    bus.abort = 1'b0;
    push_grant(1, 2);
    step_check();
    bus.req = '0;
    drain();

    // Reset in the middle of requester 2's interval.
    set_dur(2, 8);
    bus.req = 4'b0100;
    for (int k = 8; k >= 6; k--) push(4'b0100, '0, 1'b1, N'(k));
    step_check();
    bus.req = '0;
    repeat (2) step_check();
    clr = 1'b1;
    push_idle();
    step_check();
    clr = 1'b0;
    bus.req = 4'b1010;
    push_grant(1, 2);
    step_check();
    bus.req = 4'b1000;
    drain();
    bus.req = '0;
    push_idle();
    step_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
